// File: rtl/myfilter_outfifo_if.sv
// -----------------------------------------------------------------------------
// myfilter_outfifo_if
// Groups the two streams of the myfilter output stage into one bundle:
//   - the filtered-sample strobe coming out of myfilter (ext_out/extvalid_out)
//   - the valid/ready stream going on to the DAC/serialiser (m_data/m_valid/m_ready)
// Modports:
//   master : the surrounding system (filter producer and downstream consumer)
//   slave  : the output FIFO itself
// -----------------------------------------------------------------------------
interface myfilter_outfifo_if #(
    parameter int DATABITS = 24
);
    logic [DATABITS-1:0] ext_out;       // sample from myfilter
    logic                extvalid_out;  // one-cycle strobe: ext_out valid
    logic [DATABITS-1:0] m_data;        // head-of-FIFO sample
    logic                m_valid;       // m_data valid
    logic                m_ready;       // consumer accepts m_data

    modport master (
        output ext_out,
        output extvalid_out,
        output m_ready,
        input  m_data,
        input  m_valid
    );

    modport slave (
        input  ext_out,
        input  extvalid_out,
        input  m_ready,
        output m_data,
        output m_valid
    );
endinterface

// File: rtl/myfilter_outfifo.sv
// -----------------------------------------------------------------------------
// myfilter_outfifo
// Downstream output stage of myfilter. Every strobed filter sample is written
// into a first-word-fall-through FIFO and re-presented on a valid/ready stream.
// Fill level, a sticky overflow flag and an accepted-sample counter are exported
// for debug and assertion binding.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   bus        : slave side of myfilter_outfifo_if (ext_out/extvalid_out in,
//                m_data/m_valid out, m_ready in)
//   clr        : synchronous flush, beats push and pop
//   level      : occupancy 0..DEPTH
//   full/empty : level == DEPTH / level == 0
//   overflow   : sticky, a sample was dropped because the FIFO was full
//   sample_cnt : number of samples written into the FIFO (wraps silently)
// -----------------------------------------------------------------------------
module myfilter_outfifo #(
    parameter int DATABITS = 24,
    parameter int DEPTH    = 8,
    parameter int CNTBITS  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    myfilter_outfifo_if.slave        bus,
    input  logic                     clr,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [CNTBITS-1:0]       sample_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATABITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [LW-1:0]       r_level;
    logic                r_overflow;
    logic [CNTBITS-1:0]  r_sample_cnt;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_drop;

    assign w_full  = (r_level == LW'(DEPTH));
    assign w_empty = (r_level == '0);

    // A pop frees a slot in the same edge, so a full FIFO can still accept.
    assign w_pop  = !w_empty && bus.m_ready && !clr;
    assign w_push = bus.extvalid_out && !clr && (!w_full || w_pop);
    assign w_drop = bus.extvalid_out && !clr && w_full && !w_pop;

    // NOTE: storage has no reset; the pointers and level alone decide which
    // entries are meaningful, and a reset-free array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.ext_out;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // the same pre-edge values of w_push/w_pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_sample_cnt <= '0;
        end else if (clr) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_sample_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr     <= r_wr_ptr + AW'(1);
                r_sample_cnt <= r_sample_cnt + CNTBITS'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Head entry is masked to zero while empty so stale or uninitialised
    // memory never reaches the consumer.
    assign bus.m_valid = !w_empty;
    assign bus.m_data  = w_empty ? '0 : r_mem[r_rd_ptr];

    assign level      = r_level;
    assign full       = w_full;
    assign empty      = w_empty;
    assign overflow   = r_overflow;
    assign sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_myfilter_outfifo.sv
// -----------------------------------------------------------------------------
// tb_myfilter_outfifo
// Directed stimulus for myfilter_outfifo. The driver pushes every sample it
// expects to come out into a queue; an independent monitor pops and compares
// whenever the DUT transfers a word on the output stream.
// -----------------------------------------------------------------------------
module tb_myfilter_outfifo;

    localparam int DATABITS = 24;
    localparam int DEPTH    = 8;
    localparam int CNTBITS  = 16;

    logic                  clk;
    logic                  rst;
    logic                  clr;
    logic [$clog2(DEPTH):0] level;
    logic                  full;
    logic                  empty;
    logic                  overflow;
    logic [CNTBITS-1:0]    sample_cnt;

    int checks   = 0;
    int failures = 0;

    logic [DATABITS-1:0] exp_q [$];

    myfilter_outfifo_if #(.DATABITS(DATABITS)) bus ();

    myfilter_outfifo #(
        .DATABITS (DATABITS),
        .DEPTH    (DEPTH),
        .CNTBITS  (CNTBITS)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .clr        (clr),
        .level      (level),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .sample_cnt (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Set inputs for one cycle, then return 1 time unit after the edge.
    task automatic drive(input logic s, input logic [DATABITS-1:0] d,
                         input logic r, input logic c);
        bus.extvalid_out = s;
        bus.ext_out      = d;
        bus.m_ready      = r;
        clr              = c;
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        exp_q.delete();
        drive(1'b0, '0, 1'b0, 1'b1);
    endtask

    // Monitor: a transfer happens at the next rising edge whenever these hold.
    always @(negedge clk) begin
        if (!rst && bus.m_valid && bus.m_ready && !clr) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL stream_unexpected: got 0x%0h expected no transfer", bus.m_data);
            end else begin
                check("stream_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst              = 1'b1;
        clr              = 1'b0;
        bus.ext_out      = '0;
        bus.extvalid_out = 1'b0;
        bus.m_ready      = 1'b0;

        // ---------------- power-on reset values ----------------
        #2;
        check("rst_empty",    32'(empty), 32'd1);
        check("rst_full",     32'(full), 32'd0);
        check("rst_m_valid",  32'(bus.m_valid), 32'd0);
        check("rst_m_data",   32'(bus.m_data), 32'd0);
        check("rst_level",    32'(level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ---------------- reset mid-stream ----------------
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(DATABITS'(24'hA1 + i));
            drive(1'b1, DATABITS'(24'hA1 + i), 1'b0, 1'b0);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        check("midrst_level_before", 32'(level), 32'd3);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_level",    32'(level), 32'd0);
        check("midrst_empty",    32'(empty), 32'd1);
        check("midrst_m_valid",  32'(bus.m_valid), 32'd0);
        check("midrst_m_data",   32'(bus.m_data), 32'd0);
        check("midrst_cnt",      32'(sample_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        check("postrst_empty",  32'(empty), 32'd1);
        check("postrst_m_data", 32'(bus.m_data), 32'd0);
        check("postrst_cnt",    32'(sample_cnt), 32'd0);

        // ---------------- basic flow, m_ready held high ----------------
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                exp_q.push_back(DATABITS'(24'h11 * (i / 2 + 1)));
                drive(1'b1, DATABITS'(24'h11 * (i / 2 + 1)), 1'b1, 1'b0);
                check("basic_valid_next_cycle", 32'(bus.m_valid), 32'd1);
                check("basic_data_next_cycle", 32'(bus.m_data), 32'h11 * (i / 2 + 1));
            end else begin
                drive(1'b0, '0, 1'b1, 1'b0);
            end
            check("basic_level_le1", 32'(level <= 1), 32'd1);
        end
        check("basic_empty", 32'(empty), 32'd1);
        check("basic_cnt",   32'(sample_cnt), 32'd3);
        check("basic_drained", 32'(exp_q.size()), 32'd0);

        // ---------------- fill and overflow ----------------
        flush();
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) exp_q.push_back(DATABITS'(i));
            drive(1'b1, DATABITS'(i), 1'b0, 1'b0);
            if (i == 8) begin
                check("fill_full",     32'(full), 32'd1);
                check("fill_level",    32'(level), 32'd8);
                check("fill_overflow_before", 32'(overflow), 32'd0);
            end
        end
        check("ovf_flag",  32'(overflow), 32'd1);
        check("ovf_cnt",   32'(sample_cnt), 32'd8);
        check("ovf_level", 32'(level), 32'd8);
        for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b1, 1'b0);
        check("ovf_drain_empty",  32'(empty), 32'd1);
        check("ovf_sticky",       32'(overflow), 32'd1);
        check("ovf_drained",      32'(exp_q.size()), 32'd0);
        check("ovf_empty_m_data", 32'(bus.m_data), 32'd0);

        // ---------------- full with push and pop together ----------------
        flush();
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(DATABITS'(i));
            drive(1'b1, DATABITS'(i), 1'b0, 1'b0);
        end
        exp_q.push_back(DATABITS'(9));
        drive(1'b1, DATABITS'(9), 1'b1, 1'b0);
        check("fullpp_overflow", 32'(overflow), 32'd0);
        check("fullpp_level",    32'(level), 32'd8);
        check("fullpp_cnt",      32'(sample_cnt), 32'd9);
        for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b1, 1'b0);
        check("fullpp_drained", 32'(exp_q.size()), 32'd0);
        check("fullpp_empty",   32'(empty), 32'd1);

        // ---------------- wrap-around with varying m_ready ----------------
        flush();
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(DATABITS'(24'h100 + i));
            drive(1'b1, DATABITS'(24'h100 + i), (i % 3) != 0, 1'b0);
        end
        for (int i = 0; i < 20 && !empty; i++) drive(1'b0, '0, 1'b1, 1'b0);
        check("wrap_empty",   32'(empty), 32'd1);
        check("wrap_cnt",     32'(sample_cnt), 32'd20);
        check("wrap_drained", 32'(exp_q.size()), 32'd0);

        // ---------------- clr priority ----------------
        flush();
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back(DATABITS'(24'h200 + i));
            drive(1'b1, DATABITS'(24'h200 + i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b0);
        check("clr_pre_level",    32'(level), 32'd5);
        check("clr_pre_overflow", 32'(overflow), 32'd1);
        exp_q.delete();
        drive(1'b1, DATABITS'(24'h2FF), 1'b1, 1'b1);
        check("clr_level",    32'(level), 32'd0);
        check("clr_empty",    32'(empty), 32'd1);
        check("clr_overflow", 32'(overflow), 32'd0);
        check("clr_cnt",      32'(sample_cnt), 32'd0);
        check("clr_m_valid",  32'(bus.m_valid), 32'd0);
        check("clr_m_data",   32'(bus.m_data), 32'd0);

        // Quiet inputs: nothing may appear on the stream.
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b0);
        check("quiet_empty", 32'(empty), 32'd1);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/myfilter_outfifo.md
Name: myfilter_outfifo

Overview:
Downstream output stage of myfilter. Captures each filtered sample presented on ext_out/extvalid_out into a first-word-fall-through FIFO. Re-presents the samples on a valid/ready stream to the next consumer (the DAC/serialiser side). Provides fill level, a sticky overflow flag and an accepted-sample counter for debug and assertion binding.

Parameters:
DATABITS, 24 (same value as myfilter_pkg::DATABITS), sample width
DEPTH, 8, FIFO entries; must be a power of two and >= 2
CNTBITS, 16, width of accepted-sample counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
ext_out  input  DATABITS  sample from myfilter
extvalid_out  input  1  one-cycle strobe: ext_out valid this cycle
clr  input  1  synchronous flush
m_data  output  DATABITS  head-of-FIFO sample
m_valid  output  1  m_data valid
m_ready  input  1  consumer accepts m_data this cycle
level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
full  output  1  level == DEPTH
empty  output  1  level == 0
overflow  output  1  sticky: a sample was dropped
sample_cnt  output  CNTBITS  count of samples written into FIFO

Behaviour:
- Reset (rst=1, asynchronous):
  - pointers, level, overflow and sample_cnt go to 0 immediately.
  - empty=1, full=0, m_valid=0, m_data=0.
  - Memory contents are not reset.
  - A reset mid-operation discards all stored samples.
- Storage: DEPTH-entry array; wr_ptr and rd_ptr are log2(DEPTH) bits, wrapping naturally DEPTH-1 -> 0. level is a separate counter.
- push = extvalid_out && !clr && (!full || pop).
- pop = m_valid && m_ready && !clr.
- Push: on the clock edge, mem[wr_ptr] <= ext_out, wr_ptr++, sample_cnt++.
  - sample_cnt wraps 2^CNTBITS-1 -> 0 with no flag.
- Pop: rd_ptr++ on the clock edge.
- level update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Outputs, combinational from registers:
  - m_valid = !empty.
  - m_data = mem[rd_ptr] when !empty, else all-zero (never X).
- Latency: a strobe in cycle N makes m_valid=1 with m_data=ext_out in cycle N+1. There is no bypass: a push into an empty FIFO cannot be popped in the same cycle.
- Full with push and pop in the same cycle: both happen, the sample is accepted, level stays DEPTH.
- Full with push and no pop: the sample is dropped, overflow <= 1, sample_cnt unchanged, contents unchanged.
- overflow stays 1 until clr or rst.
- m_ready while empty: ignored, no pointer movement.
- m_ready may be held high continuously; one sample transfers per cycle.
- clr=1 (takes priority over push and pop in the same cycle):
  - pointers, level, overflow and sample_cnt <= 0.
  - A coincident strobe is discarded and not counted.
  - In the next cycle m_valid=0.
- No X on any output while rst=0, including when inputs are quiet.

Test Plan:
- Reset check: assert rst mid-stream with level=3 -> outputs go to reset values in the same cycle; after release, empty=1, m_data=0, sample_cnt=0.
- Basic flow, DEPTH=8, m_ready=1: strobes in cycles 0,2,4 with ext_out 0x000011, 0x000022, 0x000033 -> m_valid high in cycles 1,3,5 with those values in order; level never exceeds 1; sample_cnt=3.
- Fill and overflow, m_ready=0: 9 strobes with values 1..9 -> after 8 strobes full=1, level=8; 9th sets overflow=1, sample_cnt=8; draining yields 1..8 with 9 absent; overflow stays 1 when empty.
- Full with simultaneous push and pop: FIFO full with 1..8, strobe value 9 and m_ready=1 in the same cycle -> overflow stays 0, level=8; drain order 2..9.
- Wrap-around: 20 push/pop cycles with varying m_ready -> output order equals input order across pointer wrap; sample_cnt=20.
- clr priority: level=5, overflow=1, clr with strobe and m_ready=1 in the same cycle -> next cycle level=0, empty=1, overflow=0, sample_cnt=0, m_valid=0.
